// File: rtl/or_agg_pkg.sv
// Shared constants and helpers for the OR event aggregator.
// lowest_set() is also used by the bench reference model.
package or_agg_pkg;

    localparam int N_SRC_DEFAULT = 8;

    function automatic logic [5:0] lowest_set(input logic [63:0] vec);
        logic [5:0] r;
        r = '0;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i]) r = 6'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/or_event_aggregator_if.sv
// Source/mask/clear inputs and irq/status outputs of the aggregator.
// master drives the event side, slave is the aggregator itself.
interface or_event_aggregator_if
    import or_agg_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT,
    parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
    logic [N_SRC-1:0] src_i;
    logic             mask_we_i;
    logic [N_SRC-1:0] mask_wdata_i;
    logic             clr_en_i;
    logic [N_SRC-1:0] clr_vec_i;
    logic [N_SRC-1:0] pending_o;
    logic             irq_o;
    logic             first_vld_o;
    logic [IDX_W-1:0] first_idx_o;

    modport master (
        output src_i, mask_we_i, mask_wdata_i,
        output clr_en_i, clr_vec_i,
        input  pending_o, irq_o,
        input  first_vld_o, first_idx_o
    );

    modport slave (
        input  src_i, mask_we_i, mask_wdata_i,
        input  clr_en_i, clr_vec_i,
        output pending_o, irq_o,
        output first_vld_o, first_idx_o
    );
endinterface

// File: rtl/or_agg_prio_enc.sv
// Combinational lowest-index finder over an N_SRC-bit vector.
// idx is 0 whenever no bit is set.
module or_agg_prio_enc #(
    parameter int N_SRC = 8,
    parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] i_vec,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    // Scan downwards so the lowest set index is written last.
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_vld = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/or_event_aggregator.sv
// Sticky, maskable N-source event aggregator with lowest-index report.
// Define OR_AGG_EDGE_EN for rising-edge capture instead of level capture.
module or_event_aggregator
    import or_agg_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT,
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input logic                  clk,
    input logic                  rst_n,
    or_event_aggregator_if.slave bus
);

    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic             r_irq;
    logic [IDX_W-1:0] r_idx;

    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_masked;
    logic             w_vld;
    logic [IDX_W-1:0] w_idx;

`ifdef OR_AGG_EDGE_EN
    logic [N_SRC-1:0] r_src_q;

    always_ff @(posedge clk) begin
        if (!rst_n) r_src_q <= '0;
        else        r_src_q <= bus.src_i;
    end

    assign w_set = bus.src_i & ~r_src_q;
`else
    assign w_set = bus.src_i;
`endif

    assign w_clr    = bus.clr_en_i ? bus.clr_vec_i : '0;
    assign w_masked = r_pending & r_mask;

    or_agg_prio_enc #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_prio (
        .i_vec (w_masked),
        .o_vld (w_vld),
        .o_idx (w_idx)
    );

    // Set is OR-ed after the clear so a same-cycle event is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_irq     <= 1'b0;
            r_idx     <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (bus.mask_we_i) r_mask <= bus.mask_wdata_i;
            r_irq <= w_vld;
            r_idx <= w_idx;
        end
    end

    assign bus.pending_o   = r_pending;
    assign bus.irq_o       = r_irq;
    assign bus.first_vld_o = r_irq;
    assign bus.first_idx_o = r_idx;

endmodule

// File: tb/tb_or_event_aggregator.sv
// Self-checking bench for or_event_aggregator (N_SRC = 8).
// Directed vector table, hand sequences and a randomized model run.
module tb_or_event_aggregator;
    import or_agg_pkg::*;

`ifdef OR_AGG_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    or_event_aggregator_if #(.N_SRC(8)) bus ();

    or_event_aggregator #(.N_SRC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst_n;
        logic [7:0] src;
        bit         mwe;
        logic [7:0] mwd;
        bit         cen;
        logic [7:0] cvec;
        logic [7:0] e_pend;
        bit         e_irq;
        logic [2:0] e_idx;
    } vec_t;

    vec_t tbl[19];

    bit m_pend[8];
    bit m_mask[8];
    bit m_srcq[8];
    bit m_irq;
    logic [2:0] m_idx;

    task automatic chk(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pk(input bit a[8]);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = a[i];
        return v;
    endfunction

    // Reference: apply this cycle's inputs to the model state.
    task automatic model_step();
        logic [63:0] mv;
        bit ev;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0;
                m_mask[i] = 0;
                m_srcq[i] = 0;
            end
            m_irq = 0;
            m_idx = 0;
        end else begin
            mv = '0;
            for (int i = 0; i < 8; i++)
                mv[i] = m_pend[i] & m_mask[i];
            m_irq = (mv != 0);
            m_idx = 3'(lowest_set(mv));
            for (int i = 0; i < 8; i++) begin
                ev = bus.src_i[i] && !(EDGE && m_srcq[i]);
                if (ev)
                    m_pend[i] = 1;
                else if (bus.clr_en_i && bus.clr_vec_i[i])
                    m_pend[i] = 0;
                if (bus.mask_we_i) m_mask[i] = bus.mask_wdata_i[i];
                m_srcq[i] = bus.src_i[i];
            end
        end
    endtask

    task automatic drive(input bit r, input logic [7:0] s,
                         input bit mwe, input logic [7:0] mwd,
                         input bit cen, input logic [7:0] cv);
        rst_n            = r;
        bus.src_i        = s;
        bus.mask_we_i    = mwe;
        bus.mask_wdata_i = mwd;
        bus.clr_en_i     = cen;
        bus.clr_vec_i    = cv;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".pend"}, bus.pending_o, pk(m_pend));
        chk({nm, ".irq"}, 8'(bus.irq_o), 8'(m_irq));
        chk({nm, ".vld"}, 8'(bus.first_vld_o), 8'(m_irq));
        chk({nm, ".idx"}, 8'(bus.first_idx_o), 8'(m_idx));
    endtask

    task automatic step(input bit r, input logic [7:0] s,
                        input bit mwe, input logic [7:0] mwd,
                        input bit cen, input logic [7:0] cv,
                        input string nm);
        drive(r, s, mwe, mwd, cen, cv);
        tick();
        chk_model(nm);
    endtask

    initial begin
        drive(0, 8'h00, 0, 8'h00, 0, 8'h00);

        // rst src mwe mwd cen cvec | pend irq idx
        tbl[0]  = '{0, 8'hFF, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0};
        tbl[1]  = '{0, 8'hFF, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0};
        tbl[2]  = '{1, 8'h00, 1, 8'h0F, 0, 8'h00, 8'h00, 0, 0};
        tbl[3]  = '{1, 8'h20, 0, 8'h00, 0, 8'h00, 8'h20, 0, 0};
        tbl[4]  = '{1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h20, 0, 0};
        tbl[5]  = '{1, 8'h00, 1, 8'hFF, 0, 8'h00, 8'h20, 0, 0};
        tbl[6]  = '{1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h20, 1, 5};
        tbl[7]  = '{1, 8'h00, 0, 8'h00, 1, 8'h20, 8'h00, 1, 5};
        tbl[8]  = '{1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0};
        tbl[9]  = '{1, 8'h90, 0, 8'h00, 0, 8'h00, 8'h90, 0, 0};
        tbl[10] = '{1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h90, 1, 4};
        tbl[11] = '{1, 8'h00, 0, 8'h00, 1, 8'h10, 8'h80, 1, 4};
        tbl[12] = '{1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h80, 1, 7};
        tbl[13] = '{1, 8'h00, 0, 8'h00, 1, 8'h80, 8'h00, 1, 7};
        tbl[14] = '{1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0};
        tbl[15] = '{1, 8'h08, 0, 8'h00, 1, 8'h08, 8'h08, 0, 0};
        tbl[16] = '{1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h08, 1, 3};
        tbl[17] = '{1, 8'h00, 0, 8'h00, 1, 8'hFF, 8'h00, 1, 3};
        tbl[18] = '{1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0};

        for (int k = 0; k < 19; k++) begin
            drive(tbl[k].rst_n, tbl[k].src, tbl[k].mwe,
                  tbl[k].mwd, tbl[k].cen, tbl[k].cvec);
            tick();
            chk($sformatf("tbl%0d.pend", k),
                bus.pending_o, tbl[k].e_pend);
            chk($sformatf("tbl%0d.irq", k),
                8'(bus.irq_o), 8'(tbl[k].e_irq));
            chk($sformatf("tbl%0d.vld", k),
                8'(bus.first_vld_o), 8'(tbl[k].e_irq));
            chk($sformatf("tbl%0d.idx", k),
                8'(bus.first_idx_o), 8'(tbl[k].e_idx));
        end

        // Held-high source against a clear.
        step(1, 8'h00, 1, 8'hFF, 0, 8'h00, "lv.mask");
        step(1, 8'h01, 0, 8'h00, 0, 8'h00, "lv.set");
        step(1, 8'h01, 0, 8'h00, 1, 8'h01, "lv.clr");
        chk("lv.bit0", 8'(bus.pending_o[0]), EDGE ? 8'd0 : 8'd1);
        step(1, 8'h01, 0, 8'h00, 0, 8'h00, "lv.hold");
        chk("lv.hold0", 8'(bus.pending_o[0]), EDGE ? 8'd0 : 8'd1);
        step(1, 8'h00, 0, 8'h00, 1, 8'h01, "lv.rel");
        step(1, 8'h00, 0, 8'h00, 0, 8'h00, "lv.idle");

        // Reset in the middle of activity.
        step(1, 8'hA5, 0, 8'h00, 0, 8'h00, "mr.set");
        step(1, 8'h00, 0, 8'h00, 0, 8'h00, "mr.irq");
        chk("mr.pendA5", bus.pending_o, 8'hA5);
        chk("mr.irq1", 8'(bus.irq_o), 8'd1);
        step(0, 8'h00, 0, 8'h00, 0, 8'h00, "mr.rst");
        chk("mr.rstpend", bus.pending_o, 8'h00);
        chk("mr.rstirq", 8'(bus.irq_o), 8'd0);
        step(1, 8'h00, 1, 8'h0F, 0, 8'h00, "mr.m0F");
        step(1, 8'h20, 0, 8'h00, 0, 8'h00, "mr.p20");
        step(1, 8'h00, 1, 8'hFF, 0, 8'h00, "mr.mFF");
        step(1, 8'h00, 0, 8'h00, 0, 8'h00, "mr.w");
        chk("mr.idx5", 8'(bus.first_idx_o), 8'd5);
        chk("mr.irqlate", 8'(bus.irq_o), 8'd1);

        // Source high across reset release.
        step(0, 8'h40, 0, 8'h00, 0, 8'h00, "rr.rst");
        step(1, 8'h40, 0, 8'h00, 0, 8'h00, "rr.rel");
        chk("rr.pend", bus.pending_o, 8'h40);

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 59) != 0),
                 8'($urandom) & 8'($urandom),
                 ($urandom_range(0, 5) == 0), 8'($urandom),
                 ($urandom_range(0, 2) == 0), 8'($urandom),
                 $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
